// File: rtl/display_source_scheduler.sv
// Time-shares one binary-to-BCD converter and a 4-digit display among NUM_SRC value sources.
// Optional feature macro: DISPLAY_SCHED_ALERT_EN (alert preemption); when undefined i_alert is unused.
module display_source_scheduler #(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned DWELL_CYCLES = 200_000_000,
    parameter int unsigned BCD_TIMEOUT  = 64
) (
    input  logic                       i_clk,
    input  logic                       i_resetn,
    input  logic [16*NUM_SRC-1:0]      i_value,
    input  logic [NUM_SRC-1:0]         i_enable,
    input  logic [NUM_SRC-1:0]         i_alert,
    output logic                       o_bcd_start,
    output logic [15:0]                o_bcd_value,
    input  logic                       i_bcd_dv,
    input  logic [15:0]                i_bcd,
    output logic [15:0]                o_bcd,
    output logic [$clog2(NUM_SRC)-1:0] o_src,
    output logic                       o_busy,
    output logic                       o_err
);

    localparam int unsigned SRC_W   = $clog2(NUM_SRC);
    localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES);
    localparam int unsigned TMO_W   = $clog2(BCD_TIMEOUT + 1);
    localparam logic [15:0] BLANK   = 16'hFFFF;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state, state_d;
    logic [SRC_W-1:0]   ptr, ptr_d;
    logic [DWELL_W-1:0] dwell_cnt, dwell_d;
    logic [TMO_W-1:0]   tmo_cnt, tmo_d;
    logic               rec_valid, rec_valid_d;
    logic [SRC_W-1:0]   rec_src, rec_src_d;
    logic [15:0]        rec_value, rec_value_d;
    logic               bcd_start_d, busy_d, err_d;
    logic [15:0]        bcd_value_d, bcd_d;
    logic [SRC_W-1:0]   src_d;

    logic               alert_any;
    logic [SRC_W-1:0]   alert_idx;
    logic               tgt_valid;
    logic [SRC_W-1:0]   tgt_idx;
    logic [15:0]        tgt_value;
    logic [SRC_W-1:0]   ptr_next_en;
    logic [SRC_W-1:0]   scan_idx;
    logic               scan_found;
    logic [15:0]        value_arr [NUM_SRC];

    for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_value
        assign value_arr[g] = i_value[16*g +: 16];
    end

`ifdef DISPLAY_SCHED_ALERT_EN
    // Lowest asserted alert index wins.
    always_comb begin
        alert_any = 1'b0;
        alert_idx = '0;
        for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
            if (i_alert[SRC_W'(k)]) begin
                alert_any = 1'b1;
                alert_idx = SRC_W'(k);
            end
        end
    end
`else
    logic unused_alert;
    assign unused_alert = ^i_alert;
    assign alert_any    = 1'b0;
    assign alert_idx    = '0;
`endif

    // Target: alert first, else the rotation pointer if it is enabled.
    always_comb begin
        tgt_valid = 1'b0;
        tgt_idx   = ptr;
        if (alert_any) begin
            tgt_valid = 1'b1;
            tgt_idx   = alert_idx;
        end else if (i_enable[ptr]) begin
            tgt_valid = 1'b1;
        end
        tgt_value = value_arr[tgt_idx];
    end

    // Next enabled index after the pointer, wrapping; the pointer itself is the last candidate.
    always_comb begin
        ptr_next_en = ptr;
        scan_found  = 1'b0;
        scan_idx    = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            scan_idx = SRC_W'((32'(ptr) + i) % NUM_SRC);
            if (!scan_found && i_enable[scan_idx]) begin
                scan_found  = 1'b1;
                ptr_next_en = scan_idx;
            end
        end
    end

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        dwell_d     = dwell_cnt;
        tmo_d       = tmo_cnt;
        rec_valid_d = rec_valid;
        rec_src_d   = rec_src;
        rec_value_d = rec_value;
        bcd_start_d = 1'b0;
        bcd_value_d = o_bcd_value;
        bcd_d       = o_bcd;
        src_d       = o_src;
        busy_d      = o_busy;
        err_d       = o_err;

        // Rotation: frozen under alert, idle with nothing enabled, skips a disabled pointer at once.
        if (alert_any) begin
            dwell_d = '0;
        end else if (|i_enable) begin
            if (!i_enable[ptr] || dwell_cnt == DWELL_W'(DWELL_CYCLES - 1)) begin
                ptr_d   = ptr_next_en;
                dwell_d = '0;
            end else begin
                dwell_d = dwell_cnt + DWELL_W'(1);
            end
        end

        case (state)
            S_IDLE: begin
                if (tgt_valid) begin
                    if (!rec_valid || tgt_idx != rec_src || tgt_value != rec_value) begin
                        bcd_value_d = tgt_value;
                        bcd_start_d = 1'b1;
                        rec_valid_d = 1'b1;
                        rec_src_d   = tgt_idx;
                        rec_value_d = tgt_value;
                        busy_d      = 1'b1;
                        tmo_d       = '0;
                        state_d     = S_WAIT;
                    end
                end else begin
                    bcd_d       = BLANK;
                    rec_valid_d = 1'b0;
                end
            end
            S_WAIT: begin
                // dv takes precedence over a timeout expiring on the same cycle.
                if (i_bcd_dv) begin
                    bcd_d   = (rec_value > 16'd9999) ? BLANK : i_bcd;
                    src_d   = rec_src;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (tmo_cnt == TMO_W'(BCD_TIMEOUT - 1)) begin
                    err_d       = 1'b1;
                    bcd_d       = BLANK;
                    rec_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    tmo_d = tmo_cnt + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state       <= S_IDLE;
            ptr         <= '0;
            dwell_cnt   <= '0;
            tmo_cnt     <= '0;
            rec_valid   <= 1'b0;
            rec_src     <= '0;
            rec_value   <= '0;
            o_bcd_start <= 1'b0;
            o_bcd_value <= '0;
            o_bcd       <= BLANK;
            o_src       <= '0;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            dwell_cnt   <= dwell_d;
            tmo_cnt     <= tmo_d;
            rec_valid   <= rec_valid_d;
            rec_src     <= rec_src_d;
            rec_value   <= rec_value_d;
            o_bcd_start <= bcd_start_d;
            o_bcd_value <= bcd_value_d;
            o_bcd       <= bcd_d;
            o_src       <= src_d;
            o_busy      <= busy_d;
            o_err       <= err_d;
        end
    end

endmodule
